// File: rtl/uart_boot_streamer_pkg.sv
// Shared definitions for the bootloader UART image streamer.
// Optional feature macro: UART_PARITY_EN (adds an even parity bit to every byte).
package uart_boot_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hFE;

`ifdef UART_PARITY_EN
  localparam int BITS_PER_BYTE = 11;  // start + 8 data + parity + stop
`else
  localparam int BITS_PER_BYTE = 10;  // start + 8 data + stop
`endif

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_FETCH,
    ST_WAIT,
    ST_DATA,
    ST_CSUM,
    ST_DONE
  } state_t;

  // Even parity: the bit that makes the total number of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_boot_streamer_if.sv
// Word-read bus between the streamer (master) and the image memory (slave).
interface uart_boot_streamer_if #(
  parameter int ADDR_W = 14
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [31:0]       rd_data;

  modport master (output rd_req, output rd_addr, input rd_valid, input rd_data);
  modport slave  (input rd_req, input rd_addr, output rd_valid, output rd_data);
endinterface

// File: rtl/uart_boot_streamer_tx_byte.sv
// UART byte serializer with valid/ready input. Frame: start, 8 data bits LSB
// first, optional even parity (UART_PARITY_EN), one stop bit.
// in_ready is also high during the last cycle of the stop bit so a following
// byte starts with no idle cycle in between.
module uart_tx_byte
  import uart_boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       tx
);

  localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam int             SW        = BITS_PER_BYTE - 1;
  localparam logic [3:0]     BIT_LAST  = 4'(BITS_PER_BYTE - 1);

  logic          active_q;
  logic [CW-1:0] baud_q;
  logic [3:0]    bit_q;
  logic [SW-1:0] shift_q;
  logic [SW-1:0] frame;
  logic          bit_end;
  logic          byte_end;

  assign bit_end  = active_q && (baud_q == BAUD_LAST);
  assign byte_end = bit_end && (bit_q == BIT_LAST);
  assign in_ready = !active_q || byte_end;

  // Bits that follow the start bit, in transmit order from bit 0 upward.
`ifdef UART_PARITY_EN
  assign frame = {1'b1, even_parity(in_data), in_data};
`else
  assign frame = {1'b1, in_data};
`endif

  // Baud and bit counters; tx is driven straight from a flop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '1;
      tx       <= 1'b1;
    end else if (in_valid && in_ready) begin
      active_q <= 1'b1;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= frame;
      tx       <= 1'b0;
    end else if (byte_end) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      tx       <= 1'b1;
    end else if (bit_end) begin
      baud_q   <= '0;
      bit_q    <= bit_q + 4'd1;
      tx       <= shift_q[0];
      shift_q  <= {1'b1, shift_q[SW-1:1]};
    end else if (active_q) begin
      baud_q   <= baud_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_boot_streamer.sv
// Bootloader image streamer: sends SYNC, LEN_LO, LEN_HI, image words (LSB byte
// first) and an XOR checksum of the data bytes over a UART.
// The fetch of each word is issued as soon as the previous byte has been
// handed to the serializer, so a read that returns within one byte time adds
// no gap on the line. Honours UART_PARITY_EN through uart_tx_byte.
module uart_boot_streamer
  import uart_boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 14
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [15:0]          word_count,
  uart_boot_streamer_if.master mem,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  state_t            state_q, state_d;
  logic              armed_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       count_q;
  logic [15:0]       remaining_q;
  logic [31:0]       word_q;
  logic [1:0]        byte_idx_q;
  logic [7:0]        csum_q;
  logic              csum_sent_q;

  logic              byte_valid;
  logic              byte_ready;
  logic [7:0]        byte_data;
  logic              byte_fire;
  logic              start_ok;
  logic              rd_req;

  // armed_q blocks a start that coincides with the first cycle after reset release.
  assign start_ok  = start && armed_q && (state_q == ST_IDLE);
  assign byte_fire = byte_valid && byte_ready;

  assign mem.rd_req  = rd_req;
  assign mem.rd_addr = addr_q;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clock    (clock),
    .reset    (reset),
    .in_valid (byte_valid),
    .in_ready (byte_ready),
    .in_data  (byte_data),
    .tx       (tx)
  );

  // Framing FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Framing FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_ok) state_d = ST_SYNC;
      ST_SYNC:   if (byte_fire) state_d = ST_LEN_LO;
      ST_LEN_LO: if (byte_fire) state_d = ST_LEN_HI;
      ST_LEN_HI: if (byte_fire) state_d = (count_q == 16'd0) ? ST_CSUM : ST_FETCH;
      ST_FETCH:  state_d = ST_WAIT;
      ST_WAIT:   if (mem.rd_valid) state_d = ST_DATA;
      ST_DATA:   if (byte_fire && (byte_idx_q == 2'd3))
                   state_d = (remaining_q == 16'd1) ? ST_CSUM : ST_FETCH;
      ST_CSUM:   if (csum_sent_q && byte_ready) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Framing FSM outputs: byte presented to the serializer, read request, status.
  always_comb begin
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    rd_req     = 1'b0;
    busy       = (state_q != ST_IDLE);
    done       = 1'b0;
    case (state_q)
      ST_SYNC: begin
        byte_valid = 1'b1;
        byte_data  = SYNC_BYTE;
      end
      ST_LEN_LO: begin
        byte_valid = 1'b1;
        byte_data  = count_q[7:0];
      end
      ST_LEN_HI: begin
        byte_valid = 1'b1;
        byte_data  = count_q[15:8];
      end
      ST_FETCH: rd_req = 1'b1;
      ST_DATA: begin
        byte_valid = 1'b1;
        case (byte_idx_q)
          2'd0:    byte_data = word_q[7:0];
          2'd1:    byte_data = word_q[15:8];
          2'd2:    byte_data = word_q[23:16];
          default: byte_data = word_q[31:24];
        endcase
      end
      ST_CSUM: begin
        byte_valid = !csum_sent_q;
        byte_data  = csum_q;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Frame bookkeeping: length, address, word buffer, byte index and checksum.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      armed_q     <= 1'b0;
      addr_q      <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      word_q      <= '0;
      byte_idx_q  <= '0;
      csum_q      <= '0;
      csum_sent_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      if (start_ok) begin
        count_q     <= word_count;
        remaining_q <= word_count;
        addr_q      <= '0;
        byte_idx_q  <= '0;
        csum_q      <= '0;
        csum_sent_q <= 1'b0;
      end
      if ((state_q == ST_WAIT) && mem.rd_valid) begin
        word_q     <= mem.rd_data;
        byte_idx_q <= '0;
      end
      if ((state_q == ST_DATA) && byte_fire) begin
        csum_q     <= csum_q ^ byte_data;
        byte_idx_q <= byte_idx_q + 2'd1;
        if (byte_idx_q == 2'd3) begin
          addr_q      <= addr_q + 1'b1;
          remaining_q <= remaining_q - 16'd1;
        end
      end
      if ((state_q == ST_CSUM) && byte_fire) csum_sent_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_boot_streamer.sv
// Scoreboard bench for uart_boot_streamer: a UART decoder pops expected bytes,
// a memory model pops expected read addresses, a done monitor checks timing.
module tb_uart_boot_streamer;
  localparam int CPB = 4;
  localparam int AW  = 14;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] word_count = 16'd0;
  logic        tx, busy, done;

  uart_boot_streamer_if #(.ADDR_W(AW)) mem_if ();

  uart_boot_streamer #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .mem        (mem_if),
    .tx         (tx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int dec_cnt = 0;
  int rd_req_cnt = 0;
  int rst_evt = 0;
  int last_stop_end = -1;
  int lat = 1;
  logic [31:0] mem [0:3];
  logic [7:0]  exp_bytes[$];
  logic [AW-1:0] exp_addr_q[$];
  int starts[$];

  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge reset) rst_evt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory model: answers each rd_req after 'lat' cycles.
  initial begin
    logic [AW-1:0] a;
    mem_if.rd_valid = 1'b0;
    mem_if.rd_data  = 32'h0;
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && mem_if.rd_req === 1'b1) begin
        rd_req_cnt++;
        a = mem_if.rd_addr;
        check("rd_req_expected", (exp_addr_q.size() > 0), 1);
        if (exp_addr_q.size() > 0) check("rd_addr", a, exp_addr_q.pop_front());
        repeat (lat) @(negedge clock);
        if (reset === 1'b1) check("rd_addr_stable", mem_if.rd_addr, a);
        mem_if.rd_data  = mem[a[1:0]];
        mem_if.rd_valid = 1'b1;
        @(negedge clock);
        mem_if.rd_valid = 1'b0;
      end
    end
  end

  // UART decoder: samples mid-bit, pops the scoreboard per received byte.
  initial begin
    logic [NB-1:0] bits;
    int t0, r0;
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && tx === 1'b0) begin
        t0 = cyc;
        r0 = rst_evt;
        @(negedge clock);
        @(negedge clock);
        for (int k = 0; k < NB; k++) begin
          if (k > 0) repeat (CPB) @(negedge clock);
          bits[k] = tx;
        end
        @(negedge clock);
        if (rst_evt == r0) begin
          dec_cnt++;
          starts.push_back(t0);
          last_stop_end = t0 + NB * CPB;
          check("start_bit", bits[0], 1'b0);
          check("stop_bit", bits[NB-1], 1'b1);
`ifdef UART_PARITY_EN
          check("parity_bit", bits[9], ^bits[8:1]);
`endif
          check("byte_expected", (exp_bytes.size() > 0), 1);
          if (exp_bytes.size() > 0) check("byte", bits[8:1], exp_bytes.pop_front());
        end
      end
    end
  end

  // Done monitor: one cycle after the last stop bit, with nothing left to send.
  initial begin
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && done === 1'b1) begin
        done_cnt++;
        check("done_timing", cyc, last_stop_end);
        check("done_queue_empty", exp_bytes.size(), 0);
      end
    end
  end

  task automatic pulse_start(input logic [15:0] n);
    @(negedge clock);
    start = 1'b1;
    word_count = n;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("done_seen", (done_cnt != d0), 1);
    @(negedge clock);
    check("busy_after_done", busy, 1'b0);
  endtask

  function automatic int count_gaps();
    int g = 0;
    for (int i = 1; i < starts.size(); i++)
      if (starts[i] - starts[i-1] != NB * CPB) g++;
    return g;
  endfunction

  task automatic run_frame(input logic [15:0] n, input int budget);
    rd_req_cnt = 0;
    starts.delete();
    pulse_start(n);
    check("busy_after_start", busy, 1'b1);
    wait_done(budget);
  endtask

  initial begin
    int d0, n;
    mem[0] = 32'h11223344;
    mem[1] = 32'hA5A5A5A5;
    mem[2] = 32'h00000003;
    mem[3] = 32'hDEADBEEF;
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rd_req", mem_if.rd_req, 1'b0);
    check("rst_rd_addr", mem_if.rd_addr, 0);

    // start in the same cycle reset is released: ignored
    @(negedge clock);
    reset = 1'b1;
    start = 1'b1;
    word_count = 16'd0;
    @(negedge clock);
    start = 1'b0;
    check("start_at_release_busy", busy, 1'b0);
    repeat (200) @(negedge clock);
    check("start_at_release_no_bytes", dec_cnt, 0);

    // empty image
    exp_bytes = '{8'hFE, 8'h00, 8'h00, 8'h00};
    run_frame(16'd0, 1000);
    check("empty_rd_req_cnt", rd_req_cnt, 0);
    check("empty_byte_cnt", starts.size(), 4);

    // two words, read latency 1: back-to-back bytes
    lat = 1;
    exp_bytes = '{8'hFE, 8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                  8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h44};
    exp_addr_q = '{14'd0, 14'd1};
    run_frame(16'd2, 2000);
    check("lat1_rd_req_cnt", rd_req_cnt, 2);
    check("lat1_gaps", count_gaps(), 0);

    // same image, read latency beyond a byte time: idle gaps, same bytes
    lat = 60;
    exp_bytes = '{8'hFE, 8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                  8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h44};
    exp_addr_q = '{14'd0, 14'd1};
    run_frame(16'd2, 3000);
    check("lat60_rd_req_cnt", rd_req_cnt, 2);
    check("lat60_gaps_present", (count_gaps() > 0), 1);

    // start pulsed again mid-frame: ignored
    lat = 1;
    mem[0] = 32'hDEADBEEF;
    exp_bytes = '{8'hFE, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    exp_addr_q = '{14'd0};
    d0 = done_cnt;
    rd_req_cnt = 0;
    starts.delete();
    pulse_start(16'd1);
    repeat (100) @(negedge clock);
    pulse_start(16'd5);
    wait_done(2000);
    repeat (400) @(negedge clock);
    check("restart_done_cnt", done_cnt - d0, 1);
    check("restart_rd_req_cnt", rd_req_cnt, 1);
    check("restart_idle", busy, 1'b0);

    // reset during a data byte, then a full fresh frame
    mem[0] = 32'h11223344;
    exp_bytes = '{8'hFE, 8'h03, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    exp_addr_q = '{14'd0, 14'd1, 14'd2};
    d0 = dec_cnt;
    pulse_start(16'd3);
    n = 0;
    while (dec_cnt < d0 + 4 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check("midreset_reached_data", (dec_cnt >= d0 + 4), 1);
    n = 0;
    while (tx !== 1'b0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("midreset_in_start_bit", tx, 1'b0);
    d0 = done_cnt;
    reset = 1'b0;
    #1;
    check("midreset_tx", tx, 1'b1);
    check("midreset_busy", busy, 1'b0);
    exp_bytes.delete();
    exp_addr_q.delete();
    repeat (5) @(negedge clock);
    reset = 1'b1;
    repeat (60) @(negedge clock);
    check("midreset_no_done", done_cnt, d0);
    exp_bytes = '{8'hFE, 8'h03, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                  8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'h47};
    exp_addr_q = '{14'd0, 14'd1, 14'd2};
    run_frame(16'd3, 3000);
    check("fresh_rd_req_cnt", rd_req_cnt, 3);
    check("fresh_byte_cnt", starts.size(), 16);
    check("fresh_gaps", count_gaps(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
